// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch front-end: issues sequential word fetches under a credit limit,
// buffers in-order responses in a small FIFO and presents one instruction per cycle.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_inc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   tag_pc     [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0] count, outstanding, drop;
    logic [CW:0]   in_use;
    logic          has_head, req_fire, rsp_ok, push, pop;

    // Request handshake: a request transfers in any cycle where imem_req_valid and
    // imem_req_ready are both high; valid never depends on ready.
    always_comb begin
        in_use         = {1'b0, count} + {1'b0, outstanding};
        has_head       = rst && (count != '0);
        imem_req_valid = rst && (in_use < LIMIT) && !redirect_valid;
        imem_req_addr  = fetch_pc;
        instr_valid    = has_head && !redirect_valid;
        instr          = has_head ? fifo_instr[rd_ptr] : 32'h0;
        pc             = has_head ? fifo_pc[rd_ptr] : 32'h0;
        pc_inc         = has_head ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (outstanding != '0);
        push           = rsp_ok && (drop == '0) && !redirect_valid;
        pop            = instr_valid && !stall;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            // Tags retire on every response, including the ones being dropped.
            if (req_fire) begin
                tag_pc[tag_wr] <= fetch_pc;
                tag_wr         <= tag_wr + 1'b1;
            end
            if (rsp_ok) tag_rd <= tag_rd + 1'b1;
            if (push) begin
                fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
                fifo_instr[wr_ptr] <= imem_rsp_data;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= wr_ptr;
                drop     <= outstanding - CW'(rsp_ok);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (rsp_ok && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && imem_rsp_valid)
            assert (outstanding != '0) else $error("imem response with no outstanding request");
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: in-order memory model plus a queue-level
// model of the buffered stream, compared against the DUT every cycle.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'h5A5A_0F0F;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr, pc, pc_inc;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_inc(pc_inc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          epoch, cyc, last_due, lat_min, lat_max, rsp_epoch;
    logic [31:0] model_fetch_pc, seq_pc, rsp_addr;
    int          errors, checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_instr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // in-order instruction memory: data = addr ^ KEY
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            rsp_addr       = mem_q[0].addr;
            rsp_epoch      = mem_q[0].epoch;
            imem_rsp_data  = mem_q[0].addr ^ KEY;
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // scoreboard: compare then advance the model by one cycle
    always @(negedge clk) begin
        bit exp_rv, exp_iv;
        int due;
        if (!rst) begin
            chk("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_instr_valid", instr_valid, 1'b0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_pc", pc, 32'h0);
            chk("rst_pc_inc", pc_inc, 32'h0);
            exp_q.delete();
            mem_q.delete();
            model_fetch_pc = RESET_PC;
            seq_pc         = RESET_PC;
            last_due       = 0;
            epoch++;
        end else begin
            exp_rv = (exp_q.size() + mem_q.size() + int'(imem_rsp_valid) < DEPTH) && !redirect_valid;
            exp_iv = (exp_q.size() != 0) && !redirect_valid;
            chk("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", imem_req_addr, model_fetch_pc);
            chk("instr_valid", instr_valid, exp_iv);
            if (exp_q.size() != 0) begin
                chk("head_pc", pc, exp_q[0]);
                chk("head_instr", instr, exp_q[0] ^ KEY);
                chk("head_pc_inc", pc_inc, exp_q[0] + 32'd4);
            end else begin
                chk("empty_pc", pc, 32'h0);
                chk("empty_instr", instr, 32'h0);
                chk("empty_pc_inc", pc_inc, 32'h0);
            end
            if (exp_iv && !stall) begin
                chk("stream_seq", pc, seq_pc);
                seq_pc = seq_pc + 32'd4;
                void'(exp_q.pop_front());
            end
            if (imem_rsp_valid && rsp_epoch == epoch && !redirect_valid)
                exp_q.push_back(rsp_addr);
            if (exp_rv && imem_req_ready) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: model_fetch_pc, epoch: epoch, due: due});
                model_fetch_pc = model_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                model_fetch_pc = redirect_pc;
                seq_pc         = redirect_pc;
            end
        end
    end

    // driver / directed sequence
    initial begin
        bit ok;
        logic [31:0] rand_pc;
        errors = 0; checks = 0; epoch = 0; cyc = 0; last_due = 0;
        lat_min = 1; lat_max = 1;
        rst = 1'b0; imem_req_ready = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        rsp_addr = 32'h0; rsp_epoch = -1;
        model_fetch_pc = RESET_PC; seq_pc = RESET_PC;
        repeat (3) cycle();

        // reset release, latency 1, ready 1
        imem_req_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("t1_first_req_valid", imem_req_valid, 1'b1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        chk("t1_cycle0_instr_valid", instr_valid, 1'b0);
        cycle(); cycle();
        @(negedge clk);
        chk("t1_cycle2_instr_valid", instr_valid, 1'b1);
        chk("t1_cycle2_pc", pc, 32'h0);
        chk("t1_cycle2_pc_inc", pc_inc, 32'h4);
        cycle();
        @(negedge clk);
        chk("t1_cycle3_pc", pc, 32'h4);
        chk("t1_cycle3_instr", instr, 32'h4 ^ KEY);
        repeat (5) cycle();

        // stall until the FIFO saturates, then drain
        stall = 1'b1;
        repeat (6) cycle();
        @(negedge clk);
        chk("t2_full_req_valid", imem_req_valid, 1'b0);
        chk("t2_full_instr_valid", instr_valid, 1'b1);
        stall = 1'b0;
        repeat (8) cycle();

        // redirect with latency 3 and requests in flight
        lat_min = 3; lat_max = 3;
        repeat (6) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        wait_instr(ok);
        chk("t3_wait_instr", ok, 1'b1);
        if (ok) chk("t3_first_pc", pc, 32'h0000_0100);
        cycle();
        repeat (4) cycle();

        // redirect coincident with a response and with stall
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("t4_redir_instr_valid", instr_valid, 1'b0);
        chk("t4_redir_req_valid", imem_req_valid, 1'b0);
        cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_next_req_valid", imem_req_valid, 1'b1);
        chk("t4_next_req_addr", imem_req_addr, 32'h0000_0200);
        cycle();
        stall = 1'b0;
        repeat (4) cycle();

        // random ready / latency / stall with occasional redirects
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            rand_pc        = $urandom();
            rand_pc[1:0]   = 2'b00;
            redirect_pc    = rand_pc;
            cycle();
        end
        imem_req_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        lat_min = 1; lat_max = 1;
        repeat (8) cycle();

        // address wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_addr_fff8", imem_req_addr, 32'hFFFF_FFF8);
        cycle();
        @(negedge clk);
        chk("t6_addr_fffc", imem_req_addr, 32'hFFFF_FFFC);
        cycle();
        @(negedge clk);
        chk("t6_wrap_valid", imem_req_valid, 1'b1);
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        repeat (6) cycle();

        // build three buffered entries, then reset
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        redirect_valid = 1'b0;
        cycle(); cycle(); cycle();
        imem_req_ready = 1'b0;
        cycle();
        @(negedge clk);
        chk("t7_pre_rst_pc", pc, 32'h0000_0040);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_rst_instr_valid", instr_valid, 1'b0);
        chk("t7_rst_pc", pc, 32'h0);
        cycle();
        @(negedge clk);
        chk("t7_rst_next_pc", pc, 32'h0);
        chk("t7_rst_next_req_valid", imem_req_valid, 1'b0);
        cycle();
        imem_req_ready = 1'b1; stall = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t7_restart_req_valid", imem_req_valid, 1'b1);
        chk("t7_restart_addr", imem_req_addr, RESET_PC);
        wait_instr(ok);
        chk("t7_wait_instr", ok, 1'b1);
        if (ok) chk("t7_restart_pc", pc, RESET_PC);
        cycle();
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Prefetching instruction fetch front-end that sits directly upstream of the decode stage and replaces the single-register PC/IMEM path. It issues sequential word fetches to a pipelined instruction memory port with a valid/ready handshake and buffers returned instructions in a small FIFO. It presents one instruction per cycle to IF/ID, honours the decode stall, and redirects on a taken branch or jump from EXE/MEM. Responses that were in flight at redirect time are discarded.

Parameters:
DEPTH, 4, FIFO entries and the maximum number of outstanding requests; must be a power of two, 2..16.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset (asserted when 0)
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch byte address, word aligned
imem_req_ready  in  1  memory accepts the request this cycle
imem_rsp_valid  in  1  response data valid; responses return in request order, latency ≥1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch/jump; driven from exe_mem branch_taken
redirect_pc  in  32  branch target
stall  in  1  decode stall (lw hazard); hold the head entry
instr_valid  out  1  head entry valid toward IF/ID
instr  out  32  head instruction
pc  out  32  address of head instruction
pc_inc  out  32  pc + 4

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-low. All state updates on posedge clk.
- State: fetch_pc (32), FIFO of {pc, instr} with rd_ptr/wr_ptr of log2(DEPTH) bits plus count (0..DEPTH), outstanding counter (0..DEPTH), drop counter (0..DEPTH).
- Reset (rst==0 at posedge): fetch_pc=RESET_PC; count, outstanding, drop, and pointers all 0. While rst==0: imem_req_valid=0, instr_valid=0, instr=0, pc=0, pc_inc=0 (masked combinationally).
- Request issue: imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid. imem_req_addr = fetch_pc. On handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1. A queue of {pc} tags of depth DEPTH records the request address in issue order.
- Response: on imem_rsp_valid, outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise write {tag pc, data} at wr_ptr and increment count.
  - Credit accounting guarantees the FIFO never overflows. A response with outstanding==0 is a protocol error: ignore it and flag it via simulation assertion.
- Output: instr_valid = (count != 0) && !redirect_valid. instr, pc, and pc_inc show the head entry combinationally and are 0 when count==0. Pop when instr_valid && !stall.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pop with count==1 plus push in the same cycle is legal; the new entry becomes head next cycle. Zero-bubble steady state is 1 instr/cycle when memory latency is 1 and ready=1.
- Redirect (redirect_valid==1), which takes priority over everything:
  - count=0; rd_ptr=wr_ptr.
  - fetch_pc = redirect_pc.
  - drop = outstanding minus (1 if imem_rsp_valid this cycle, else 0). The same-cycle response is always discarded.
  - No request issues that cycle and no pop.
  - The first post-redirect request issues the next cycle with address redirect_pc.
- Redirect while drop>0: drop is recomputed per the rule above, so earlier drops are subsumed.
- stall with count==DEPTH: issue stops (credit 0), head is held, and no data is lost.
- Fetch issue continues during stall while credit is available.
- Reset mid-operation: all counters clear. Responses arriving after reset for pre-reset requests are indistinguishable from new ones. The memory wrapper must also be reset by rst so that no pre-reset response arrives.

Test Plan:
- Reset with RESET_PC=0, memory latency 1, ready=1, no stall -> first instr_valid in cycle 2 after reset release; pc sequence 0x0,0x4,0x8… one per cycle; pc_inc = pc+4.
- stall held high for 6 cycles with DEPTH=4 -> count saturates at 4, imem_req_valid drops to 0, head pc stays constant. After release, 4 buffered entries drain in consecutive cycles with no gaps or duplicates.
- Redirect to 0x100 with 2 requests outstanding (latency 3) -> the 2 stale responses are dropped, next instr_valid has pc=0x100, and no pc from the old stream appears afterwards.
- Redirect coincident with imem_rsp_valid and with stall=1 -> the response is discarded, instr_valid=0 that cycle, and the next issued address equals redirect_pc.
- imem_req_ready random at 50% with latency 1..4 (in-order) -> output pc stream is strictly +4 sequential and count+outstanding never exceeds DEPTH.
- fetch_pc=0xFFFF_FFFC -> the next request address wraps to 0x0000_0000.
- rst asserted while count=3 -> outputs are 0 the next cycle, and a fetch restarts from RESET_PC after release.
